// File: rtl/demux_1to4_if.sv
// ---------------------------------------------------------------------------
// demux_1to4_if
//   Bus bundle for the 1-to-4 registered demultiplexer.
//   Signals:
//     d       data to route                  (WIDTH bits)
//     s0, s1  select LSB / MSB               (1 bit each)
//     y0..y3  routed outputs, one per select (WIDTH bits each)
//   Modports:
//     master  drives d/s0/s1, observes y0..y3 (the producer side)
//     slave   receives d/s0/s1, drives y0..y3 (the demultiplexer)
// ---------------------------------------------------------------------------
interface demux_1to4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;

    modport master (
        output d,
        output s0,
        output s1,
        input  y0,
        input  y1,
        input  y2,
        input  y3
    );

    modport slave (
        input  d,
        input  s0,
        input  s1,
        output y0,
        output y1,
        output y2,
        output y3
    );
endinterface

// File: rtl/demux_1to4.sv
// ---------------------------------------------------------------------------
// demux_1to4
//   1-to-4 demultiplexer with registered outputs. The data input is steered to
//   the output selected by {s1,s0}; the other three outputs are cleared. All
//   outputs come straight from flops, so latency is exactly one clock.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high; clears all outputs
//     bus   demux_1to4_if.slave: d, s0, s1 in; y0..y3 out
//   The interface instance must be built with the same WIDTH as this module.
// ---------------------------------------------------------------------------
module demux_1to4 #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    demux_1to4_if.slave  bus
);

    logic [1:0]       sel_s;
    logic [WIDTH-1:0] y0_s;
    logic [WIDTH-1:0] y1_s;
    logic [WIDTH-1:0] y2_s;
    logic [WIDTH-1:0] y3_s;
    logic [WIDTH-1:0] y0_r;
    logic [WIDTH-1:0] y1_r;
    logic [WIDTH-1:0] y2_r;
    logic [WIDTH-1:0] y3_r;

    assign sel_s = {bus.s1, bus.s0};

    // Next-value decode: only the selected output takes d, the rest stay zero.
    // An unknown select falls to the default arm and leaves every output zero.
    always_comb begin
        y0_s = {WIDTH{1'b0}};
        y1_s = {WIDTH{1'b0}};
        y2_s = {WIDTH{1'b0}};
        y3_s = {WIDTH{1'b0}};
        case (sel_s)
            2'b00:   y0_s = bus.d;
            2'b01:   y1_s = bus.d;
            2'b10:   y2_s = bus.d;
            2'b11:   y3_s = bus.d;
            default: begin
                y0_s = {WIDTH{1'b0}};
                y1_s = {WIDTH{1'b0}};
                y2_s = {WIDTH{1'b0}};
                y3_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Output registers with synchronous reset taking priority over the data path.
    always_ff @(posedge clk) begin
        if (rst) begin
            y0_r <= {WIDTH{1'b0}};
            y1_r <= {WIDTH{1'b0}};
            y2_r <= {WIDTH{1'b0}};
            y3_r <= {WIDTH{1'b0}};
        end else begin
            y0_r <= y0_s;
            y1_r <= y1_s;
            y2_r <= y2_s;
            y3_r <= y3_s;
        end
    end

    assign bus.y0 = y0_r;
    assign bus.y1 = y1_r;
    assign bus.y2 = y2_r;
    assign bus.y3 = y3_r;

endmodule

// File: tb/tb_demux_1to4.sv
// ---------------------------------------------------------------------------
// tb_demux_1to4
//   Self-checking bench for demux_1to4. Two instances share clock and reset:
//   one at WIDTH=1 and one at WIDTH=4. A reference model holds the four
//   expected outputs as an array indexed by the select value.
// ---------------------------------------------------------------------------
module tb_demux_1to4;

    logic clk;
    logic rst;

    int checks;
    int failures;

    // Expected outputs for each instance, indexed by output number.
    logic [3:0] exp1 [4];
    logic [3:0] exp4 [4];
    bit         model_valid;

    demux_1to4_if #(.WIDTH(1)) if1 ();
    demux_1to4_if #(.WIDTH(4)) if4 ();

    demux_1to4 #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    demux_1to4 #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model.
    task automatic check_all(input string phase);
        logic [3:0] act1 [4];
        logic [3:0] act4 [4];
        act1[0] = {3'b000, if1.y0};
        act1[1] = {3'b000, if1.y1};
        act1[2] = {3'b000, if1.y2};
        act1[3] = {3'b000, if1.y3};
        act4[0] = if4.y0;
        act4[1] = if4.y1;
        act4[2] = if4.y2;
        act4[3] = if4.y3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_w1_y%0d", phase, i), act1[i], exp1[i]);
            chk($sformatf("%s_w4_y%0d", phase, i), act4[i], exp4[i]);
        end
    endtask

    // Apply one cycle of stimulus. Before the edge the outputs must still hold
    // the previous values (no combinational path); after it they must match
    // the model updated with the applied inputs.
    task automatic step(input logic r, input logic d1, input logic [3:0] d4,
                        input int sel, input string tag);
        rst    = r;
        if1.d  = d1;
        if4.d  = d4;
        if1.s0 = sel[0];
        if1.s1 = sel[1];
        if4.s0 = sel[0];
        if4.s1 = sel[1];
        #1;
        if (model_valid) check_all({tag, "_hold"});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                exp1[i] = 4'h0;
                exp4[i] = 4'h0;
            end else begin
                exp1[i] = (i == sel) ? {3'b000, d1} : 4'h0;
                exp4[i] = (i == sel) ? d4 : 4'h0;
            end
        end
        model_valid = 1'b1;
        check_all(tag);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model_valid = 1'b0;
        rst    = 1'b1;
        if1.d  = 1'b0;
        if4.d  = 4'h0;
        if1.s0 = 1'b0;
        if1.s1 = 1'b0;
        if4.s0 = 1'b0;
        if4.s1 = 1'b0;

        // Reset held two cycles with data and select that would otherwise route.
        step(1'b1, 1'b1, 4'hF, 3, "rst_a");
        step(1'b1, 1'b1, 4'hF, 3, "rst_b");

        // Zero data: all outputs zero for every select.
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 4'h0, s, $sformatf("dzero_s%0d", s));

        // One-hot walk with nonzero data.
        for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 4'h5 + 4'(s), s, $sformatf("walk_s%0d", s));

        // Reset in mid-operation, then the first free edge loads from inputs.
        step(1'b0, 1'b1, 4'hC, 2, "mid_a");
        step(1'b1, 1'b1, 4'hC, 2, "mid_rst");
        step(1'b0, 1'b1, 4'h3, 1, "mid_b");

        // Select and data change on the same edge.
        step(1'b0, 1'b1, 4'h9, 0, "same_a");
        step(1'b0, 1'b0, 4'h0, 3, "same_b");

        // Wide data steering.
        step(1'b0, 1'b1, 4'hA, 2, "wide_a");
        step(1'b0, 1'b1, 4'hA, 3, "wide_b");

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            logic       r;
            logic [3:0] dv;
            int         sv;
            r  = ($urandom_range(0, 15) == 0);
            dv = 4'($urandom_range(0, 15));
            sv = int'($urandom_range(0, 3));
            step(r, dv[0], dv, sv, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
